mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter sharing one 4:1 data mux between four requesters.
- Grants one requester at a time and drives the mux select from the grant.
- Registers the selected data onto a single output bus.
- Inserts one dead cycle between grants, modelling bus turnaround for the decoder/tristate style mux.

Parameters:
- DW, 8, data width of each requester input and of dout.
- MAX_HOLD, 15, maximum consecutive grant cycles before forced release. Used only with MUX_ARB_TIMEOUT_EN. Must be ≥1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; level, held for the whole transaction.
- din0  input  DW  requester 0 data.
- din1  input  DW  requester 1 data.
- din2  input  DW  requester 2 data.
- din3  input  DW  requester 3 data.
- gnt  output  4  one-hot grant; 0000 when none.
- sel  output  2  mux select, the index of the current or last grant.
- busy  output  1  high when state is not IDLE.
- dout  output  DW  registered muxed data.
- dout_vld  output  1  dout holds data captured from the granted requester.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low, and clears all state immediately, mid-operation included.
- Reset values:
  - state=IDLE, gnt=0000, sel=00, busy=0, dout=0, dout_vld=0.
  - Internal last-grant pointer last=3, so requester 0 has first priority.
- FSM states: IDLE, GRANT, RELEASE. All outputs are registered.
- Arbitration (in IDLE or RELEASE, when req!=0):
  - Search indices (last+1)%4, (last+2)%4, ... with wrap-around.
  - Pick the first index k with req[k]=1.
  - At the edge: gnt<=onehot(k), sel<=k, last<=k, state<=GRANT.
  - IDLE with req=0: stay IDLE.
  - RELEASE with req=0: go to IDLE.
- GRANT, req[sel]=1: dout<=din[sel], dout_vld<=1. Latency from a granted-data cycle to dout is one clock.
- GRANT, req[sel]=0: gnt<=0000, dout_vld<=0, state<=RELEASE. sel is held.
- RELEASE: gnt=0000, dout_vld=0 for exactly one cycle, then re-arbitrate per the rules above.
  - Back-to-back grants therefore always have exactly one gnt=0000 cycle between them.
- dout holds its last value whenever dout_vld=0. sel never changes except at a grant edge.
- Requests asserted during GRANT or RELEASE wait. No preemption except via the optional feature.
- busy is 1 in GRANT and RELEASE, 0 in IDLE.
- Requester dropping and re-raising req during RELEASE is treated as a new request and ranked by rotation. The same requester wins only if no other is pending.

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined:
  - Hold counter, width $clog2(MAX_HOLD+1), clears on each grant and increments each GRANT cycle.
  - On the GRANT edge where MAX_HOLD grant cycles have completed and any other req bit is set: forced release, identical to a req drop (gnt<=0000, state<=RELEASE).
  - If no other requester is pending, the grant continues and the counter saturates at MAX_HOLD.
- Undefined: no counter; a grant is held until the owner drops req.

Test Plan:
- Reset: rst_n=0 with req=1111 → gnt=0000, sel=00, busy=0, dout=00, dout_vld=0 throughout reset.
- Single request:
  - req=0100, din2=8'hA5 → gnt=0100, sel=2 one edge after sampling; dout=A5, dout_vld=1 the next edge.
  - Drop req → gnt=0000 next edge; busy=0 one cycle later.
- Rotation: req=1111, each owner holds 3 grant cycles then drops for 1 cycle → grant order 0,1,2,3,0. Exactly one gnt=0000 cycle between grants.
- Wrap: with last=3, req=1001 → grant 0; after release with req still 1001 → grant 3.
- Async reset mid-grant: rst_n low between edges while gnt=0010 → gnt=0000, busy=0, dout_vld=0 immediately, without waiting for clk.
- Timeout (MUX_ARB_TIMEOUT_EN, MAX_HOLD=4):
  - req=0011 held → gnt=0001 for 4 cycles, one gap cycle, gnt=0010 for 4 cycles, then repeat.
  - req=0001 alone → gnt=0001 held indefinitely.
  - Without the macro, req=0011 held → gnt=0001 indefinitely.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Purpose  : Round-robin arbiter that shares one 4:1 data mux between four
//            requesters.
//
//            - The grant drives the mux select.
//            - The selected data is registered onto a single output bus.
//            - One dead cycle (gnt = 0000) separates consecutive grants.
//              This models bus turnaround for a decoder/tristate style mux.
//
// Revision : 1.0 - initial release
//
// Ports    : clk       in   1   system clock, rising edge
//            rst_n     in   1   asynchronous active-low reset
//            req       in   4   level request per requester
//            din0..3   in   DW  requester data
//            gnt       out  4   one-hot grant, 0000 when none
//            sel       out  2   mux select (current or last grant index)
//            busy      out  1   FSM not in IDLE
//            dout      out  DW  registered muxed data
//            dout_vld  out  1   dout holds data captured from the owner
//
// Options  : `define MUX_ARB_TIMEOUT_EN enables the hold counter.
//            With it, an owner is forced to release after MAX_HOLD grant
//            cycles whenever another requester is waiting.
// ============================================================================
module mux4_rr_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          busy,
    output logic [DW-1:0] dout,
    output logic          dout_vld
);

    // ------------------------------------------------------------------------
    // Parameter sanity: a zero hold limit would make the timeout meaningless.
    // ------------------------------------------------------------------------
    if (MAX_HOLD < 1) begin : g_chk_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be >= 1");
    end

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [3:0]      gnt_q,    gnt_d;
    logic [1:0]      sel_q,    sel_d;
    logic [1:0]      last_q,   last_d;
    logic [DW-1:0]   dout_q,   dout_d;
    logic            vld_q,    vld_d;

    logic [DW-1:0]   w_din_sel;
    logic [2:0]      w_pick;        // {found, index}
    logic            w_force_rel;

    // ------------------------------------------------------------------------
    // Rotating priority search.
    //
    // Indices are walked from the farthest (last itself) to the nearest
    // (last+1), so the nearest requesting index is the final assignment
    // and wins. The 2-bit addition wraps modulo 4 by construction.
    // ------------------------------------------------------------------------
    function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_pick = rr_pick(req, last_q);

    // ------------------------------------------------------------------------
    // Shared data mux, steered by the registered select
    // ------------------------------------------------------------------------
    always_comb begin
        w_din_sel = din0;
        case (sel_q)
            2'd0:    w_din_sel = din0;
            2'd1:    w_din_sel = din1;
            2'd2:    w_din_sel = din2;
            default: w_din_sel = din3;
        endcase
    end

`ifdef MUX_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Hold counter.
    //
    // - hold_q counts completed grant cycles of the current owner.
    // - It is cleared outside GRANT, so it reads zero on the first grant
    //   cycle.
    // - It saturates at MAX_HOLD so an unopposed owner can keep the bus
    //   forever.
    // ------------------------------------------------------------------------
    localparam int            HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);

    logic [HW-1:0] hold_q, hold_d;

    always_comb begin
        hold_d = '0;
        if (state_q == S_GRANT) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    // This edge ends the MAX_HOLD-th grant cycle and someone else is
    // waiting, so the owner is forced off the bus.
    assign w_force_rel = (hold_q >= HOLD_LAST) && (|(req & ~gnt_q));
`else
    assign w_force_rel = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        dout_d  = dout_q;
        vld_d   = vld_q;

        case (state_q)
            S_IDLE, S_RELEASE: begin
                // RELEASE is the single turnaround cycle.
                // Arbitration happens here exactly as in IDLE.
                gnt_d = 4'b0000;
                vld_d = 1'b0;
                if (w_pick[2]) begin
                    state_d = S_GRANT;
                    gnt_d   = 4'b0001 << w_pick[1:0];
                    sel_d   = w_pick[1:0];
                    last_d  = w_pick[1:0];
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_GRANT: begin
                if (req[sel_q] && !w_force_rel) begin
                    dout_d = w_din_sel;
                    vld_d  = 1'b1;
                end else begin
                    // Owner dropped (or was timed out).
                    // sel is kept so it keeps pointing at the last owner.
                    state_d = S_RELEASE;
                    gnt_d   = 4'b0000;
                    vld_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;            // requester 0 gets first priority
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign busy     = (state_q != S_IDLE);
    assign dout     = dout_q;
    assign dout_vld = vld_q;

endmodule
`default_nettype wire
